// File: rtl/dram_param.sv
`default_nettype none
// ============================================================================
// Module   : dram_param
// Brief    : Parametrised single-port data RAM with byte-lane writes, registered
//            read + valid strobe, post-reset zero fill and range detection.
// Revision : 1.0 - initial release
// ============================================================================
module dram_param #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 11,
    parameter int DEPTH          = 2048,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  read_not_write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     read_data,
    output logic                  read_valid,
    output logic                  ready,
    output logic                  addr_err
);

    localparam int              c_LANES       = DATA_W / 8;
    localparam logic [0:0]      c_S_CLEAR     = 1'b0;
    localparam logic [0:0]      c_S_IDLE      = 1'b1;
    localparam logic [0:0]      c_RESET_STATE = (CLEAR_ON_RESET != 0) ? c_S_CLEAR : c_S_IDLE;
    localparam logic [ADDR_W:0] c_DEPTH       = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_ready;
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_valid;
    logic              r_addr_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_clear_we;
    logic              w_ready_nxt;
    logic              w_accept;
    logic              w_in_range;
    logic              w_rd_acc;
    logic              w_wr_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_CLEAR: begin
                if (r_ptr == c_LAST) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ready is registered so it stays low throughout reset in both fill modes
    always_comb begin
        w_clear_we  = (r_state == c_S_CLEAR);
        w_ready_nxt = (w_state_nxt == c_S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            if (w_clear_we) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign w_accept   = cs & r_ready;
    assign w_in_range = ({1'b0, address} < c_DEPTH);
    assign w_rd_acc   = w_accept & read_not_write;
    assign w_wr_acc   = w_accept & ~read_not_write & w_in_range;

    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (byte_en[i]) begin
                    r_mem[address][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_read_valid <= w_rd_acc;
            r_addr_err   <= w_accept & ~w_in_range;
            if (w_rd_acc) begin
                r_read_data <= w_in_range ? r_mem[address] : '0;
            end
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign ready      = r_ready;
    assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dram_param
// Brief    : Randomised and directed bench for three dram_param configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_param;

    localparam int          DEP   [3] = '{2048, 1536, 16};
    localparam logic [31:0] DMASK [3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF};
    localparam logic [3:0]  BMASK [3] = '{4'h3, 4'h3, 4'hF};
    localparam logic [10:0] AMASK [3] = '{11'h7FF, 11'h7FF, 11'h00F};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cs_a   [3];
    logic        rnw_a  [3];
    logic [10:0] addr_a [3];
    logic [31:0] wd_a   [3];
    logic [3:0]  be_a   [3];

    logic [15:0] rd0, rd1;
    logic [31:0] rd2;
    logic        rv0, rv1, rv2, rdy0, rdy1, rdy2, er0, er1, er2;

    logic [31:0] rd_a  [3];
    logic        rv_a  [3];
    logic        rdy_a [3];
    logic        er_a  [3];

    assign rd_a[0]  = {16'h0, rd0};
    assign rd_a[1]  = {16'h0, rd1};
    assign rd_a[2]  = rd2;
    assign rv_a[0]  = rv0;
    assign rv_a[1]  = rv1;
    assign rv_a[2]  = rv2;
    assign rdy_a[0] = rdy0;
    assign rdy_a[1] = rdy1;
    assign rdy_a[2] = rdy2;
    assign er_a[0]  = er0;
    assign er_a[1]  = er1;
    assign er_a[2]  = er2;

    dram_param u_dut0 (
        .clk(clk), .rst_n(rst_n), .cs(cs_a[0]), .read_not_write(rnw_a[0]),
        .address(addr_a[0]), .write_data(wd_a[0][15:0]), .byte_en(be_a[0][1:0]),
        .read_data(rd0), .read_valid(rv0), .ready(rdy0), .addr_err(er0)
    );

    dram_param #(.DATA_W(16), .ADDR_W(11), .DEPTH(1536), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cs(cs_a[1]), .read_not_write(rnw_a[1]),
        .address(addr_a[1]), .write_data(wd_a[1][15:0]), .byte_en(be_a[1][1:0]),
        .read_data(rd1), .read_valid(rv1), .ready(rdy1), .addr_err(er1)
    );

    dram_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cs(cs_a[2]), .read_not_write(rnw_a[2]),
        .address(addr_a[2][3:0]), .write_data(wd_a[2]), .byte_en(be_a[2]),
        .read_data(rd2), .read_valid(rv2), .ready(rdy2), .addr_err(er2)
    );

    int checks = 0;
    int errors = 0;
    bit en_chk = 1'b0;

    // Reference model: cycles since reset release, a plain word array per
    // instance, and the expected registered outputs.
    int          since [3];
    logic [31:0] mmem  [3][2048];
    logic [31:0] e_rd  [3];
    logic        e_rv  [3];
    logic        e_rdy [3];
    logic        e_err [3];

    function automatic bit acc(int k);
        return cs_a[k] && (since[k] >= DEP[k]);
    endfunction

    function automatic bit inr(int k);
        return int'(addr_a[k]) < DEP[k];
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                since[k] <= 0;
                e_rd[k]  <= '0;
                e_rv[k]  <= 1'b0;
                e_rdy[k] <= 1'b0;
                e_err[k] <= 1'b0;
                for (int w = 0; w < 2048; w++) mmem[k][w] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                since[k] <= (since[k] < 1000000) ? since[k] + 1 : since[k];
                e_rdy[k] <= (since[k] + 1 >= DEP[k]);
                e_rv[k]  <= acc(k) && rnw_a[k];
                e_err[k] <= acc(k) && !inr(k);
                if (acc(k) && rnw_a[k])
                    e_rd[k] <= inr(k) ? mmem[k][addr_a[k]] : 32'h0;
                if (acc(k) && !rnw_a[k] && inr(k))
                    mmem[k][addr_a[k]] <= merge(mmem[k][addr_a[k]], wd_a[k], be_a[k]);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en_chk) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("read_data[%0d]", k), rd_a[k], e_rd[k]);
                chk($sformatf("read_valid[%0d]", k), 32'(rv_a[k]), 32'(e_rv[k]));
                chk($sformatf("ready[%0d]", k), 32'(rdy_a[k]), 32'(e_rdy[k]));
                chk($sformatf("addr_err[%0d]", k), 32'(er_a[k]), 32'(e_err[k]));
            end
        end
    end

    task automatic set_in(int k, bit c, bit r, int a, logic [31:0] d, logic [3:0] b);
        cs_a[k]   = c;
        rnw_a[k]  = r;
        addr_a[k] = 11'(a) & AMASK[k];
        wd_a[k]   = d & DMASK[k];
        be_a[k]   = b & BMASK[k];
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Counts cycles from reset release to ready while issuing writes that
    // must be dropped because the fill is still running.
    task automatic wait_ready(string tag);
        int got [3];
        got = '{0, 0, 0};
        for (int n = 1; n <= 5000; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (n < DEP[k] - 4) set_in(k, 1'b1, 1'b0, 5, 32'hFFFFFFFF, 4'hF);
                else                set_in(k, 1'b0, 1'b0, 0, 32'h0, 4'h0);
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                if (got[k] == 0 && rdy_a[k]) got[k] = n;
            end
            if (got[0] != 0 && got[1] != 0 && got[2] != 0) break;
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_ready_cycles[%0d]", tag, k), 32'(got[k]), 32'(DEP[k]));
    endtask

    function automatic logic [31:0] pat(int i);
        return (32'h01010101 * 32'(i)) ^ 32'hC0DE0000;
    endfunction

    initial begin
        int a;
        rst_n = 1'b1;
        idle_all();
        #3 rst_n = 1'b0;
        repeat (3) tick();
        en_chk = 1'b1;
        #1;
        chk("reset_ready", 32'(rdy0), 32'h0);
        chk("reset_rdata", 32'(rd0), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        wait_ready("fill");

        // Fresh memory reads back zero, including words written during the fill
        set_in(0, 1'b1, 1'b1, 5, 32'h0, 4'h0);
        set_in(1, 1'b1, 1'b1, 1535, 32'h0, 4'h0);
        tick();
        chk("t1_rd5", rd_a[0], 32'h0);
        chk("t1_rv5", 32'(rv_a[0]), 32'h1);
        chk("t1_last_err", 32'(er_a[1]), 32'h0);
        idle_all();

        set_in(0, 1'b1, 1'b0, 16, 32'h003F, 4'h3);
        tick();
        set_in(0, 1'b1, 1'b1, 16, 32'h0, 4'h0);
        tick();
        idle_all();
        chk("t2_rd", rd_a[0], 32'h003F);
        chk("t2_rv", 32'(rv_a[0]), 32'h1);
        tick();
        chk("t2_rv_drop", 32'(rv_a[0]), 32'h0);
        chk("t2_rd_hold", rd_a[0], 32'h003F);

        set_in(0, 1'b1, 1'b0, 24, 32'hABCD, 4'h3);
        tick();
        set_in(0, 1'b1, 1'b0, 24, 32'h1200, 4'h2);
        tick();
        set_in(0, 1'b1, 1'b1, 24, 32'h0, 4'h0);
        tick();
        idle_all();
        chk("t3_rd", rd_a[0], 32'h12CD);

        set_in(1, 1'b1, 1'b0, 1600, 32'h5555, 4'h3);
        tick();
        chk("t4_wr_err", 32'(er_a[1]), 32'h1);
        chk("t4_wr_rv", 32'(rv_a[1]), 32'h0);
        set_in(1, 1'b1, 1'b1, 1600, 32'h0, 4'h0);
        tick();
        chk("t4_rd", rd_a[1], 32'h0);
        chk("t4_rv", 32'(rv_a[1]), 32'h1);
        chk("t4_rd_err", 32'(er_a[1]), 32'h1);
        set_in(1, 1'b1, 1'b1, 64, 32'h0, 4'h0);
        tick();
        idle_all();
        chk("t4_alias", rd_a[1], 32'h0);
        chk("t4_alias_err", 32'(er_a[1]), 32'h0);

        for (int i = 0; i < 16; i++) begin
            set_in(2, 1'b1, 1'b0, i, pat(i), 4'hF);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            set_in(2, 1'b1, 1'b1, i, 32'h0, 4'h0);
            tick();
            chk($sformatf("t6_rv[%0d]", i), 32'(rv_a[2]), 32'h1);
            chk($sformatf("t6_rd[%0d]", i), rd_a[2], pat(i));
        end
        idle_all();
        tick();
        chk("t6_rv_end", 32'(rv_a[2]), 32'h0);

        // Reset mid-access, then again part way through the refill
        set_in(0, 1'b1, 1'b1, 24, 32'h0, 4'h0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_rd", rd_a[0], 32'h0);
        chk("t5_rst_rdy", 32'(rdy_a[0]), 32'h0);
        chk("t5_rst_rv", 32'(rv_a[0]), 32'h0);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (1000) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_mid_rv", 32'(rv_a[0]), 32'h0);
        chk("t5_mid_err", 32'(er_a[0]), 32'h0);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        wait_ready("refill");
        set_in(0, 1'b1, 1'b1, 24, 32'h0, 4'h0);
        tick();
        idle_all();
        chk("t5_rd24", rd_a[0], 32'h0);

        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0:       a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                                             : int'($urandom_range(0, 31));
                    1:       a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1520, 1551))
                                                             : int'($urandom_range(0, 31));
                    default: a = int'($urandom_range(0, 15));
                endcase
                set_in(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
                       $urandom, 4'($urandom_range(0, 15)));
            end
            tick();
        end
        idle_all();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
